iob_eth_tx_builder: RTL and testbench



---
 rtl/iob_eth_tx_builder_pkg.sv | 29 ++
 rtl/iob_eth_tx_builder_if.sv | 39 +++
 rtl/iob_eth_tx_builder.sv | 152 +++++++++++++++
 tb/tb_iob_eth_tx_builder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_eth_tx_builder_pkg.sv
//==============================================================================
// Module   : iob_eth_tx_builder_pkg
// Brief    : Shared constants and state encoding for the Ethernet TX builder.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package iob_eth_tx_builder_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] PAD_BYTE      = 8'h00;

  // Must match the preamble length assumed by the transmitter.
  localparam int DEFAULT_PREAMBLE_LEN = 7;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRE       = 3'd1,
    S_SFD       = 3'd2,
    S_PAYLOAD   = 3'd3,
    S_PAD       = 3'd4,
    S_LAUNCH    = 3'd5,
    S_WAIT_DONE = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/iob_eth_tx_builder_if.sv
//==============================================================================
// Module   : iob_eth_tx_builder_if
// Brief    : Payload stream, TX-buffer write port and transmitter handshake.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface iob_eth_tx_builder_if #(
  parameter int ADDR_W = 11
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_wdata;
  logic [ADDR_W-1:0] nbytes;
  logic              send;
  logic              tx_ready;
  logic              done;
  logic              err_oversize;

  // Environment side: payload source and transmitter.
  modport master (
    output in_valid, in_data, in_last, tx_ready,
    input  in_ready, buf_wr_en, buf_addr, buf_wdata, nbytes, send, done, err_oversize
  );

  // Frame builder side.
  modport slave (
    input  in_valid, in_data, in_last, tx_ready,
    output in_ready, buf_wr_en, buf_addr, buf_wdata, nbytes, send, done, err_oversize
  );

endinterface

`default_nettype wire

// File: rtl/iob_eth_tx_builder.sv
//==============================================================================
// Module   : iob_eth_tx_builder
// Brief    : Writes preamble, SFD, payload and zero pad into the TX buffer,
//            then requests transmission and waits for the transmitter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module iob_eth_tx_builder
  import iob_eth_tx_builder_pkg::*;
#(
  parameter int PREAMBLE_LEN = DEFAULT_PREAMBLE_LEN,
  parameter int MIN_PAYLOAD  = 60,
  parameter int MAX_PAYLOAD  = 1514,
  parameter int ADDR_W       = 11
) (
  input logic                 clk,
  input logic                 rst,
  iob_eth_tx_builder_if.slave bus
);

  localparam logic [ADDR_W-1:0] c_PRE_LEN  = ADDR_W'(PREAMBLE_LEN);
  localparam logic [ADDR_W-1:0] c_PRE_LAST = ADDR_W'(PREAMBLE_LEN - 1);
  localparam logic [ADDR_W-1:0] c_HDR_LEN  = ADDR_W'(PREAMBLE_LEN + 1);
  localparam logic [ADDR_W-1:0] c_MIN      = ADDR_W'(MIN_PAYLOAD);
  localparam logic [ADDR_W-1:0] c_MAX      = ADDR_W'(MAX_PAYLOAD);

  generate
    if (PREAMBLE_LEN + 1 + MAX_PAYLOAD >= (1 << ADDR_W)) begin : g_size_check
      $error("iob_eth_tx_builder: ADDR_W too small for PREAMBLE_LEN+1+MAX_PAYLOAD");
    end
  endgenerate

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_in_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic [ADDR_W-1:0] r_nbytes;
  logic              r_send;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_room;
  logic [ADDR_W-1:0] w_cnt_inc;
  logic [ADDR_W-1:0] w_cnt_next;
  logic [ADDR_W-1:0] w_wr_addr;

  assign w_accept   = (r_state == S_PAYLOAD) && r_in_ready && bus.in_valid;
  assign w_room     = (r_cnt < c_MAX);
  assign w_cnt_inc  = r_cnt + ADDR_W'(1);
  assign w_cnt_next = w_room ? w_cnt_inc : r_cnt;
  assign w_wr_addr  = c_HDR_LEN + r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_nbytes   <= '0;
      r_send     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid && bus.tx_ready) begin
            r_state <= S_PRE;
            r_err   <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
          end
        end
        S_PRE: begin
          r_wr_en <= 1'b1;
          r_addr  <= r_ptr;
          r_wdata <= PREAMBLE_BYTE;
          r_ptr   <= r_ptr + ADDR_W'(1);
          if (r_ptr == c_PRE_LAST) r_state <= S_SFD;
        end
        S_SFD: begin
          r_wr_en    <= 1'b1;
          r_addr     <= c_PRE_LEN;
          r_wdata    <= SFD_BYTE;
          r_in_ready <= 1'b1;
          r_state    <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (w_accept) begin
            // Bytes past MAX_PAYLOAD are still consumed so the source drains.
            if (w_room) begin
              r_wr_en <= 1'b1;
              r_addr  <= w_wr_addr;
              r_wdata <= bus.in_data;
              r_cnt   <= w_cnt_inc;
            end else begin
              r_err <= 1'b1;
            end
            if (bus.in_last) begin
              r_in_ready <= 1'b0;
              r_state    <= (w_cnt_next < c_MIN) ? S_PAD : S_LAUNCH;
            end
          end
        end
        S_PAD: begin
          r_wr_en <= 1'b1;
          r_addr  <= w_wr_addr;
          r_wdata <= PAD_BYTE;
          r_cnt   <= w_cnt_inc;
          if (w_cnt_inc == c_MIN) r_state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_nbytes <= c_HDR_LEN + r_cnt;
          if (!r_send) begin
            r_send <= 1'b1;
          end else if (!bus.tx_ready) begin
            r_send  <= 1'b0;
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (bus.tx_ready) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.buf_wr_en    = r_wr_en;
  assign bus.buf_addr     = r_addr;
  assign bus.buf_wdata    = r_wdata;
  assign bus.nbytes       = r_nbytes;
  assign bus.send         = r_send;
  assign bus.done         = r_done;
  assign bus.err_oversize = r_err;

endmodule

`default_nettype wire

// File: tb/tb_iob_eth_tx_builder.sv
//==============================================================================
// Module   : tb_iob_eth_tx_builder
// Brief    : Self-checking bench for iob_eth_tx_builder (table + random frames).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_iob_eth_tx_builder;

  localparam int PRE  = 7;
  localparam int MINP = 60;
  localparam int MAXP = 1514;
  localparam int AW   = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iob_eth_tx_builder_if #(.ADDR_W(AW)) bus ();

  iob_eth_tx_builder #(
    .PREAMBLE_LEN(PRE),
    .MIN_PAYLOAD (MINP),
    .MAX_PAYLOAD (MAXP),
    .ADDR_W      (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Observed buffer image and event log, sampled mid-cycle.
  logic [7:0] mem  [2048];
  int         tag  [2048];
  int         wcyc [2048];
  int         acc_cyc [16384];
  int cyc = 0, wr_cnt = 0, acc_cnt = 0, done_cnt = 0, viol = 0;
  int last_wr_cyc = 0, send_rise_cyc = 0, done_cyc = 0;
  logic prev_send = 1'b0;
  int frame_id = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.buf_wr_en) begin
      mem[bus.buf_addr]  <= bus.buf_wdata;
      tag[bus.buf_addr]  <= frame_id;
      wcyc[bus.buf_addr] <= cyc;
      wr_cnt      <= wr_cnt + 1;
      last_wr_cyc <= cyc;
      if (bus.send) viol <= viol + 1;
    end
    if (bus.in_valid && bus.in_ready) begin
      if (acc_cnt < 16384) acc_cyc[acc_cnt] <= cyc;
      acc_cnt <= acc_cnt + 1;
    end
    if (bus.send && !prev_send) send_rise_cyc <= cyc;
    prev_send <= bus.send;
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  // Reference model of the on-wire image for the current frame.
  logic [7:0] pay[$];
  logic [7:0] exp_img[$];
  int  exp_nb;
  bit  exp_err;
  int  b_wr, b_acc, b_viol;
  int  prev_done = -1;

  typedef struct {
    int n;
    int bubble;
    int nb;
    bit err;
  } vec_t;
  vec_t tbl[8];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prep(int n, bit rnd);
    int stored;
    pay = {};
    for (int i = 0; i < n; i++) pay.push_back(rnd ? 8'($urandom) : 8'(i));
    exp_img = {};
    for (int i = 0; i < PRE; i++) exp_img.push_back(8'h55);
    exp_img.push_back(8'hD5);
    stored = (n < MAXP) ? n : MAXP;
    for (int i = 0; i < stored; i++) exp_img.push_back(pay[i]);
    while (exp_img.size() < PRE + 1 + MINP) exp_img.push_back(8'h00);
    exp_nb  = exp_img.size();
    exp_err = (n > MAXP);
    frame_id++;
    b_wr   = wr_cnt;
    b_acc  = acc_cnt;
    b_viol = viol;
  endtask

  task automatic drive_n(int bubble, int stop);
    int idx = 0;
    int guard = 0;
    bit v, acc;
    while (idx < stop && guard < 20000) begin
      v = ($urandom_range(0, 99) >= bubble);
      bus.in_valid = v;
      bus.in_data  = pay[idx];
      bus.in_last  = (idx == pay.size() - 1);
      acc = v && bus.in_ready;
      tick();
      guard++;
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("drive_accepted_in_budget", idx, stop);
  endtask

  task automatic holdoff(int cycles);
    int rdy = 0;
    int w0 = wr_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = pay[0];
    bus.in_last  = (pay.size() == 1);
    repeat (cycles) begin
      tick();
      if (bus.in_ready) rdy++;
    end
    check("holdoff_in_ready", rdy, 0);
    check("holdoff_writes", wr_cnt - w0, 0);
  endtask

  task automatic launch();
    int g = 0;
    bit held = 1'b1;
    while (!bus.send && g < 300) begin tick(); g++; end
    check("send_rise", bus.send, 1);
    check("nbytes", bus.nbytes, exp_nb);
    repeat (3) begin
      tick();
      if (!bus.send) held = 1'b0;
    end
    check("send_held_while_tx_ready", held, 1);
    bus.tx_ready = 1'b0;
    g = 0;
    tick();
    while (bus.send && g < 10) begin tick(); g++; end
    check("send_drop", bus.send, 0);
  endtask

  task automatic check_frame(int bubble);
    int errs = 0;
    check("write_count", wr_cnt - b_wr, exp_nb);
    for (int a = 0; a < exp_nb; a++)
      if (mem[a] !== exp_img[a] || tag[a] != frame_id) errs++;
    check("image_bytes_wrong", errs, 0);
    check("err_oversize", bus.err_oversize, exp_err);
    check("bytes_accepted", acc_cnt - b_acc, pay.size());
    check("write_while_send", viol - b_viol, 0);
    if (!exp_err) check("send_after_last_write", send_rise_cyc - last_wr_cyc, 1);
    if (bubble == 0) check("first_accept_latency", acc_cyc[b_acc] - wcyc[0], PRE);
    if (prev_done >= 0) begin
      check("b2b_preamble_after_done", wcyc[0] > prev_done, 1);
      prev_done = -1;
    end
  endtask

  task automatic complete(int nb);
    int g = 0;
    int bd = done_cnt;
    bus.tx_ready = 1'b1;
    while (!bus.done && g < 20) begin tick(); g++; end
    check("done_pulse", bus.done, 1);
    check("nbytes_stable", bus.nbytes, nb);
    @(negedge clk);
    #1;
    check("done_count", done_cnt - bd, 1);
    tick();
    check("done_single_cycle", bus.done, 0);
  endtask

  task automatic run_frame(int n, int bubble, bit rnd);
    prep(n, rnd);
    drive_n(bubble, n);
    launch();
    check_frame(bubble);
    complete(exp_nb);
  endtask

  initial begin
    int a_nb;
    tbl[0] = '{64,   0,  72,   1'b0};
    tbl[1] = '{10,   0,  68,   1'b0};
    tbl[2] = '{1600, 0,  1522, 1'b1};
    tbl[3] = '{60,   0,  68,   1'b0};
    tbl[4] = '{60,   40, 68,   1'b0};
    tbl[5] = '{1,    0,  68,   1'b0};
    tbl[6] = '{1514, 0,  1522, 1'b0};
    tbl[7] = '{61,   25, 69,   1'b0};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {bus.in_ready, bus.buf_wr_en, bus.send, bus.done, bus.err_oversize,
                            bus.buf_addr, bus.buf_wdata, bus.nbytes}, 0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) begin
      prep(tbl[k].n, 1'b0);
      if (k == 0) begin
        bus.tx_ready = 1'b0;
        holdoff(10);
        bus.tx_ready = 1'b1;
      end
      drive_n(tbl[k].bubble, tbl[k].n);
      launch();
      check("table_nbytes", bus.nbytes, tbl[k].nb);
      check("table_err_oversize", bus.err_oversize, tbl[k].err);
      check_frame(tbl[k].bubble);
      complete(tbl[k].nb);
    end

    // Back-to-back: next frame waits in WAIT_DONE until done.
    prep(30, 1'b1);
    drive_n(0, 30);
    launch();
    check_frame(0);
    a_nb = exp_nb;
    prep(70, 1'b1);
    holdoff(8);
    complete(a_nb);
    prev_done = done_cyc;
    drive_n(0, 70);
    launch();
    check_frame(0);
    complete(exp_nb);

    // Reset in the middle of PAYLOAD.
    prep(20, 1'b0);
    drive_n(0, 5);
    rst = 1'b1;
    tick();
    check("midframe_reset_outputs", {bus.in_ready, bus.buf_wr_en, bus.send, bus.done,
                                     bus.err_oversize, bus.buf_addr, bus.buf_wdata, bus.nbytes}, 0);
    rst = 1'b0;
    tick();
    run_frame(64, 0, 1'b1);

    for (int r = 0; r < 8; r++) begin
      int n, bub;
      n   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1505, 1530)) : int'($urandom_range(1, 130));
      bub = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(5, 50));
      run_frame(n, bub, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
